// File: rtl/image_uart_tx.sv
// Frame-to-UART serializer: sync byte, then each pixel as a high/low 8N1 byte pair.
// A byte transmitter FSM is driven by a frame-level control FSM over a load strobe.
module image_uart_tx #(
  parameter int         BIT_DEPTH    = 12,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         PIXEL_COUNT  = 307200,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset_bar,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 pixValid,
  input  logic [BIT_DEPTH-1:0] pixData,
  output logic                 pixReady,
  output logic                 txd
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(PIXEL_COUNT + 1);
  localparam logic [CLK_W-1:0] BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXEL_COUNT);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {IDLE, SYNC, WAIT_PIX, SEND_HI, SEND_LO, FINISH} ctl_state_t;

  tx_state_t      tx_state, tx_state_next;
  ctl_state_t     state, state_next;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     tx_shift;
  logic [7:0]     tx_byte;
  logic           tx_load;
  logic           bit_tick;
  logic           stop_tick;
  logic           tx_ready;
  logic [CNT_W-1:0] pix_cnt;
  logic           lo_loaded;
  logic [BIT_DEPTH-1:0] pix_hold;

  function automatic logic [7:0] hi_byte(input logic [BIT_DEPTH-1:0] pix);
    logic [15:0] wide;
    wide = 16'(pix);
    return wide[15:8];
  endfunction

  assign bit_tick  = (clk_cnt == BIT_LAST);
  assign stop_tick = (tx_state == TX_STOP) && bit_tick;
  // The stop bit's final clock doubles as a load slot so HI and LO bytes abut.
  assign tx_ready  = (tx_state == TX_IDLE) || stop_tick;

  // Byte transmitter
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) tx_state <= TX_IDLE;
    else            tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_state_next = TX_START;
      TX_START: if (bit_tick) tx_state_next = TX_DATA;
      TX_DATA:  if (bit_tick && bit_idx == 3'd7) tx_state_next = TX_STOP;
      TX_STOP:  if (bit_tick) tx_state_next = tx_load ? TX_START : TX_IDLE;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (tx_state == TX_IDLE || bit_tick) clk_cnt <= '0;
      else                                 clk_cnt <= clk_cnt + CLK_W'(1);
      if (tx_state != TX_DATA) bit_idx <= '0;
      else if (bit_tick)       bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_load && tx_ready)                tx_shift <= tx_byte;
    else if (tx_state == TX_DATA && bit_tick) tx_shift <= tx_shift >> 1;
  end

  // Frame control
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start && !done) state_next = SYNC;
      SYNC:     if (stop_tick) state_next = WAIT_PIX;
      WAIT_PIX: if (pixValid) state_next = SEND_HI;
      SEND_HI:  if (tx_state == TX_IDLE) state_next = SEND_LO;
      SEND_LO: begin
        if (stop_tick) begin
          if (lo_loaded)                 state_next = WAIT_PIX;
          else if (pix_cnt == PIX_LAST)  state_next = FINISH;
        end
      end
      FINISH:   if (stop_tick) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    pixReady = 1'b0;
    tx_load  = 1'b0;
    tx_byte  = SYNC_BYTE;
    case (state)
      SYNC:     tx_load = (tx_state == TX_IDLE);
      WAIT_PIX: pixReady = 1'b1;
      SEND_HI: begin
        tx_load = (tx_state == TX_IDLE);
        tx_byte = hi_byte(pix_hold);
      end
      SEND_LO: begin
        tx_load = stop_tick && !lo_loaded;
        tx_byte = pix_hold[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      pix_cnt   <= '0;
      lo_loaded <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == IDLE)                   pix_cnt <= '0;
      else if (state == WAIT_PIX && pixValid) pix_cnt <= pix_cnt + CNT_W'(1);
      lo_loaded <= (state == SEND_LO) && (state_next == SEND_LO) && (lo_loaded || tx_load);
      done      <= (state == FINISH) && stop_tick;
      busy      <= (state != IDLE) && !((state == FINISH) && stop_tick);
    end
  end

  always_ff @(posedge clock) begin
    if (pixReady && pixValid) pix_hold <= pixData;
  end

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx: three instances (12/16/9-bit pixels) with UART line decoders
// and a byte/frame-time reference computed from pixel values and stall lengths.
module tb_image_uart_tx;
  localparam int C = 4;

  logic        clock = 1'b0;
  logic        reset_bar;
  logic [2:0]  start_v;
  logic [2:0]  pv_v;
  logic [15:0] pd_all [3];
  wire  [2:0]  busy_v, done_v, pr_v, txd_v;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  rxq [3][$];
  logic [15:0] px_a [8];
  int          dly_a [8];

  always #5 clock = ~clock;

  image_uart_tx #(.BIT_DEPTH(12), .CLKS_PER_BIT(C), .PIXEL_COUNT(2), .SYNC_BYTE(8'hA5)) dut0 (
    .clock(clock), .reset_bar(reset_bar), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pixValid(pv_v[0]), .pixData(pd_all[0][11:0]), .pixReady(pr_v[0]), .txd(txd_v[0]));
  image_uart_tx #(.BIT_DEPTH(16), .CLKS_PER_BIT(C), .PIXEL_COUNT(1), .SYNC_BYTE(8'hA5)) dut1 (
    .clock(clock), .reset_bar(reset_bar), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pixValid(pv_v[1]), .pixData(pd_all[1]), .pixReady(pr_v[1]), .txd(txd_v[1]));
  image_uart_tx #(.BIT_DEPTH(9), .CLKS_PER_BIT(C), .PIXEL_COUNT(1), .SYNC_BYTE(8'hA5)) dut2 (
    .clock(clock), .reset_bar(reset_bar), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pixValid(pv_v[2]), .pixData(pd_all[2][8:0]), .pixReady(pr_v[2]), .txd(txd_v[2]));

  // Line decoders: every bit must hold its value for C samples; partial bytes cut by reset are dropped.
  for (genvar g = 0; g < 3; g++) begin : g_dec
    always begin : dec
      logic [9:0] fr;
      bit ok, aborted;
      @(negedge clock);
      if (reset_bar === 1'b1 && txd_v[g] === 1'b0) begin
        ok = 1'b1; aborted = 1'b0; fr = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < C; k++) begin
            if (b != 0 || k != 0) @(negedge clock);
            if (reset_bar !== 1'b1) aborted = 1'b1;
            if (k == 0) fr[b] = txd_v[g];
            else if (txd_v[g] !== fr[b]) ok = 1'b0;
          end
        end
        if (!aborted) begin
          vectors++;
          assert (ok && fr[0] == 1'b0 && fr[9] == 1'b1) else begin
            miscompares++;
            $error("FAIL framing dut%0d: observed bits %b stable=%0d, required start 0 stop 1 stable", g, fr, ok);
          end
          rxq[g].push_back(fr[8:1]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int g, input int np, input int bd, input int mid_start_at,
                           input bit start_on_done);
    int cycles, idx, wcnt, sumd;
    bit acc, got_done, stall_bad;
    logic [7:0]  exp_b [$];
    logic [15:0] m, p;
    sumd = 0;
    for (int i = 0; i < np; i++) sumd += dly_a[i];
    start_v[g] = 1'b1;
    @(posedge clock); #1;
    start_v[g] = 1'b0;
    cycles = 0; idx = 0; wcnt = dly_a[0]; got_done = 1'b0; stall_bad = 1'b0;
    while (!got_done && cycles < 3000) begin
      if (idx < np && wcnt == 0) begin
        pv_v[g] = 1'b1; pd_all[g] = px_a[idx];
      end else begin
        pv_v[g] = 1'b0; pd_all[g] = 16'($urandom);
      end
      start_v[g] = (cycles == mid_start_at);
      @(negedge clock);
      acc = pv_v[g] && pr_v[g];
      if (pr_v[g] && !pv_v[g] && wcnt > 0) wcnt--;
      if (pr_v[g] && txd_v[g] !== 1'b1) stall_bad = 1'b1;
      @(posedge clock); #1;
      cycles++;
      if (acc) begin
        idx++;
        wcnt = (idx < np) ? dly_a[idx] : 0;
      end
      if (cycles == 1) chk("busy_txd_after_start", {30'd0, busy_v[g], txd_v[g]}, 32'd2);
      got_done = (done_v[g] === 1'b1);
    end
    start_v[g] = 1'b0;
    chk("done_seen", {31'd0, got_done}, 32'd1);
    chk("frame_cycles", cycles, 10 * C * (1 + 2 * np) + 2 * np + 1 + sumd);
    chk("no_tx_while_ready", {31'd0, stall_bad}, 32'd0);
    pv_v[g] = 1'b0;
    start_v[g] = start_on_done;
    @(posedge clock); #1;
    start_v[g] = 1'b0;
    chk("done_pulse_width", {30'd0, done_v[g], busy_v[g]}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("idle_after_done", {30'd0, busy_v[g], txd_v[g]}, 32'd1);
    m = 16'((32'd1 << bd) - 1);
    exp_b = {8'hA5};
    for (int i = 0; i < np; i++) begin
      p = px_a[i] & m;
      exp_b.push_back(8'(p >> 8));
      exp_b.push_back(p[7:0]);
    end
    chk($sformatf("byte_count_dut%0d", g), rxq[g].size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rxq[g].size(); i++)
      chk($sformatf("byte%0d_dut%0d", i, g), {24'd0, rxq[g][i]}, {24'd0, exp_b[i]});
    rxq[g].delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    reset_bar = 1'b0;
    start_v = '0;
    pv_v = '0;
    for (int i = 0; i < 3; i++) pd_all[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    reset_bar = 1'b1;
    @(posedge clock); #1;
    chk("reset_txd", {29'd0, txd_v}, 32'd7);
    chk("reset_busy", {29'd0, busy_v}, 32'd0);
    chk("reset_ready", {29'd0, pr_v}, 32'd0);
    chk("reset_done", {29'd0, done_v}, 32'd0);
    quiet = 1'b1;
    repeat (100) begin
      @(posedge clock); #1;
      if (txd_v !== 3'b111 || busy_v !== 3'b000 || pr_v !== 3'b000 || done_v !== 3'b000) quiet = 1'b0;
    end
    chk("idle_quiet", {31'd0, quiet}, 32'd1);
    chk("idle_no_bytes", rxq[0].size() + rxq[1].size() + rxq[2].size(), 32'd0);

    px_a[0] = 16'h0ABC; px_a[1] = 16'h0123; dly_a[0] = 0; dly_a[1] = 0;
    run_frame(0, 2, 12, -1, 1'b0);

    px_a[0] = 16'($urandom); px_a[1] = 16'($urandom); dly_a[0] = 50; dly_a[1] = $urandom_range(1, 9);
    run_frame(0, 2, 12, -1, 1'b0);

    px_a[0] = 16'($urandom); px_a[1] = 16'($urandom); dly_a[0] = 0; dly_a[1] = 0;
    run_frame(0, 2, 12, 60, 1'b1);
    repeat (60) @(posedge clock);
    #1;
    chk("no_extra_frame_bytes", rxq[0].size(), 32'd0);
    chk("no_extra_frame_busy", {31'd0, busy_v[0]}, 32'd0);

    for (int f = 0; f < 4; f++) begin
      px_a[0] = 16'($urandom); px_a[1] = 16'($urandom);
      dly_a[0] = $urandom_range(0, 5); dly_a[1] = $urandom_range(0, 5);
      run_frame(0, 2, 12, -1, 1'b0);
    end

    px_a[0] = 16'hFFFF; dly_a[0] = 0;
    run_frame(1, 1, 16, -1, 1'b0);
    px_a[0] = 16'h01FF; dly_a[0] = 0;
    run_frame(2, 1, 9, -1, 1'b0);
    px_a[0] = 16'($urandom); dly_a[0] = $urandom_range(0, 7);
    run_frame(1, 1, 16, -1, 1'b0);
    px_a[0] = 16'($urandom); dly_a[0] = $urandom_range(0, 7);
    run_frame(2, 1, 9, -1, 1'b0);

    // Reset in the middle of data bit 2 of the 0x0A high byte.
    start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    pv_v[0] = 1'b1;
    pd_all[0] = 16'h0ABC;
    repeat (56) @(posedge clock);
    #1;
    chk("txd_bit2_of_0A", {31'd0, txd_v[0]}, 32'd0);
    #2 reset_bar = 1'b0;
    #1;
    chk("txd_async_reset", {31'd0, txd_v[0]}, 32'd1);
    chk("busy_async_reset", {31'd0, busy_v[0]}, 32'd0);
    pv_v[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_bar = 1'b1;
    repeat (60) @(posedge clock);
    #1;
    chk("bytes_before_reset", rxq[0].size(), 32'd1);
    rxq[0].delete();
    px_a[0] = 16'h0ABC; px_a[1] = 16'h0123; dly_a[0] = 0; dly_a[1] = 0;
    run_frame(0, 2, 12, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
